// File: rtl/maxpool2x2_stream_pkg.sv
// Shared types and helpers for the 2x2/stride-2 max-pool stage.
package maxpool2x2_stream_pkg;

  localparam int unsigned DataW = 8;

  typedef logic signed [DataW-1:0] pix_t;

  // Signed max; ties return a, which equals b anyway.
  function automatic pix_t smax8(input pix_t a, input pix_t b);
    return (a >= b) ? a : b;
  endfunction

  // Bit width needed to index n entries, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-write/one-read line buffer with combinational read holding the
// horizontal maxima of the even row of each window pair.
module pool_line_buf
  import maxpool2x2_stream_pkg::*;
#(
  parameter int unsigned Depth = 13,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  pix_t             wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output pix_t             rdata_o
);

  pix_t mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 signed max pooling over a raster-order conv output,
// one input per cycle, no backpressure.
module maxpool2x2_stream
  import maxpool2x2_stream_pkg::*;
#(
  parameter int unsigned CONV_W = 26,
  parameter int unsigned CONV_H = 26
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  input  logic       in_sof_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_last_o
);

  localparam int unsigned POOL_W = CONV_W / 2;
  localparam int unsigned POOL_H = CONV_H / 2;
  localparam int unsigned ColW   = clog2_min1(CONV_W);
  localparam int unsigned RowW   = clog2_min1(CONV_H);
  localparam int unsigned AddrW  = clog2_min1(POOL_W);

  localparam logic [ColW-1:0] ColLast     = ColW'(CONV_W - 1);
  localparam logic [RowW-1:0] RowLast     = RowW'(CONV_H - 1);
  localparam logic [ColW-1:0] ColPoolLast = ColW'(2 * POOL_W - 1);
  localparam logic [RowW-1:0] RowPoolLast = RowW'(2 * POOL_H - 1);

  logic [ColW-1:0] col_q, col_d, col_eff;
  logic [RowW-1:0] row_q, row_d, row_eff;
  pix_t            hold_q, hold_d;
  pix_t            hmax, lb_rdata;
  logic            lb_we;
  logic [AddrW-1:0] lb_addr;
  logic            out_valid_q, out_valid_d;
  pix_t            out_data_q, out_data_d;
  logic            out_last_q, out_last_d;

  pool_line_buf #(
    .Depth (POOL_W),
    .AddrW (AddrW)
  ) u_line_buf (
    .clk_i   (clk_i),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (hmax),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    // sof forces this sample to (0,0), discarding any partial window.
    col_eff     = in_sof_i ? '0 : col_q;
    row_eff     = in_sof_i ? '0 : row_q;
    lb_addr     = AddrW'(col_eff >> 1);
    hmax        = smax8(hold_q, pix_t'(in_data_i));
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    lb_we       = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;

    if (in_valid_i) begin
      if (col_eff == ColLast) begin
        col_d = '0;
        row_d = (row_eff == RowLast) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end

      // A trailing odd column or row only advances the counters.
      if (col_eff <= ColPoolLast && row_eff <= RowPoolLast) begin
        if (!col_eff[0]) begin
          hold_d = pix_t'(in_data_i);
        end else if (!row_eff[0]) begin
          lb_we = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = smax8(lb_rdata, hmax);
          out_last_d  = (col_eff == ColPoolLast) && (row_eff == RowPoolLast);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule
